mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between the fetch (I) and data (D) ports of a shared variable-latency memory.
// D wins by default; a streak counter forces an I grant after STARVE_MAX consecutive D grants.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy
);

  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t              state_reg, state_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic                kill_flag_reg, kill_flag_next;
  logic                store_reg, store_next;
  logic                i_done_reg, i_done_next;
  logic                d_done_reg, d_done_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;

  logic i_elig, d_elig, force_i, grant_d, grant_i;

  assign i_elig  = i_req & ~i_kill;
  assign d_elig  = d_req;
  assign force_i = i_elig & (streak_reg == STREAK_LIMIT);
  assign grant_d = d_elig & ~force_i;
  assign grant_i = i_elig & ~grant_d;

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    kill_flag_next = kill_flag_reg;
    store_next     = store_reg;
    i_done_next    = 1'b0;
    d_done_next    = 1'b0;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    mem_req        = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          // Issue strobe is gated by reset so nothing leaks out while rst is low
          mem_req    = rst;
          mem_wr     = d_wr;
          mem_addr   = d_addr;
          mem_wdata  = d_wdata;
          store_next = d_wr;
          state_next = BUSY_D;
          if (!i_elig)
            streak_next = '0;
          else if (streak_reg != STREAK_LIMIT)
            streak_next = streak_reg + STREAK_W'(1);
        end else if (grant_i) begin
          mem_req        = rst;
          mem_addr       = i_addr;
          streak_next    = '0;
          kill_flag_next = 1'b0;
          state_next     = BUSY_I;
        end
      end

      BUSY_I: begin
        if (i_kill)
          kill_flag_next = 1'b1;
        if (mem_done) begin
          if (kill_flag_reg || i_kill) begin
            // Redirected fetch: swallow the data and skip the completion cycle
            kill_flag_next = 1'b0;
            state_next     = IDLE;
          end else begin
            i_done_next  = 1'b1;
            i_rdata_next = mem_rdata;
            state_next   = DONE;
          end
        end
      end

      BUSY_D: begin
        if (mem_done) begin
          d_done_next = 1'b1;
          if (!store_reg)
            d_rdata_next = mem_rdata;
          state_next = DONE;
        end
      end

      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      kill_flag_reg <= 1'b0;
      store_reg     <= 1'b0;
      i_done_reg    <= 1'b0;
      d_done_reg    <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      kill_flag_reg <= kill_flag_next;
      store_reg     <= store_next;
      i_done_reg    <= i_done_next;
      d_done_reg    <= d_done_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  assign i_done  = i_done_reg;
  assign d_done  = d_done_reg;
  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;
  assign i_stall = i_req & ~i_done_reg;
  assign d_stall = d_req & ~d_done_reg;
  assign busy    = (state_reg != IDLE);

endmodule
